// File: rtl/c_add_pipe.sv
// c_add_pipe: two-stage pipelined 15-bit modular adder, B = (S + A) mod 2^15,
// with the carry chain split after bit 7 and a valid/ready handshake.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_vld, in_rdy   input handshake (in_rdy is combinational from out_rdy)
//   S, A             15-bit operands (difference, subtrahend)
//   out_vld, out_rdy output handshake
//   B, C             15-bit sum and carry out of bit 14
module c_add_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [14:0] S,
    input  logic [14:0] A,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [14:0] B,
    output logic        C
);

    localparam int unsigned W    = 15;
    localparam int unsigned LO_W = 8;
    localparam int unsigned HI_W = W - LO_W;

    // Stage 1: low-half sum plus carry, high halves passed through
    logic              s1_vld_q, s1_vld_d;
    logic [LO_W-1:0]   s1_lo_q, s1_lo_d;
    logic              s1_cy_q, s1_cy_d;
    logic [HI_W-1:0]   s1_s_hi_q, s1_s_hi_d;
    logic [HI_W-1:0]   s1_a_hi_q, s1_a_hi_d;

    // Stage 2: final result
    logic              out_vld_q, out_vld_d;
    logic [W-1:0]      b_q, b_d;
    logic              c_q, c_d;

    logic              s2_adv;
    logic              in_acc;
    logic [LO_W:0]     lo_sum;
    logic [HI_W:0]     hi_sum;

    // Handshake, adders and next-state selection
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_lo_d   = s1_lo_q;
        s1_cy_d   = s1_cy_q;
        s1_s_hi_d = s1_s_hi_q;
        s1_a_hi_d = s1_a_hi_q;
        out_vld_d = out_vld_q;
        b_d       = b_q;
        c_d       = c_q;

        s2_adv = s1_vld_q & (~out_vld_q | out_rdy);
        in_acc = in_vld & (~s1_vld_q | s2_adv);

        lo_sum = (LO_W+1)'(S[LO_W-1:0]) + (LO_W+1)'(A[LO_W-1:0]);
        hi_sum = (HI_W+1)'(s1_s_hi_q) + (HI_W+1)'(s1_a_hi_q) + (HI_W+1)'(s1_cy_q);

        if (in_acc) begin
            s1_vld_d  = 1'b1;
            s1_lo_d   = lo_sum[LO_W-1:0];
            s1_cy_d   = lo_sum[LO_W];
            s1_s_hi_d = S[W-1:LO_W];
            s1_a_hi_d = A[W-1:LO_W];
        end else if (s2_adv) begin
            s1_vld_d  = 1'b0;
        end

        if (s2_adv) begin
            out_vld_d = 1'b1;
            b_d       = {hi_sum[HI_W-1:0], s1_lo_q};
            c_d       = hi_sum[HI_W];
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_lo_q   <= '0;
            s1_cy_q   <= 1'b0;
            s1_s_hi_q <= '0;
            s1_a_hi_q <= '0;
            out_vld_q <= 1'b0;
            b_q       <= '0;
            c_q       <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_lo_q   <= s1_lo_d;
            s1_cy_q   <= s1_cy_d;
            s1_s_hi_q <= s1_s_hi_d;
            s1_a_hi_q <= s1_a_hi_d;
            out_vld_q <= out_vld_d;
            b_q       <= b_d;
            c_q       <= c_d;
        end
    end

    // Only combinational output: depends on state and out_rdy, never on in_vld
    assign in_rdy  = ~s1_vld_q | s2_adv;
    assign out_vld = out_vld_q;
    assign B       = b_q;
    assign C       = c_q;

endmodule

// File: tb/tb_c_add_pipe.sv
// tb_c_add_pipe: directed and random checks of c_add_pipe with a result
// queue holding the expected {C,B} of every accepted operand pair.
module tb_c_add_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [14:0] S;
    logic [14:0] A;
    logic        out_vld;
    logic        out_rdy;
    logic [14:0] B;
    logic        C;

    int          n_checks;
    int          n_fail;
    logic [15:0] sb[$];
    logic        fired;
    logic        accepted;
    logic [15:0] last_out;

    c_add_pipe dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .S       (S),
        .A       (A),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .B       (B),
        .C       (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, evaluate both handshakes before the next posedge
    task automatic step(input logic v, input logic [14:0] s, input logic [14:0] a,
                        input logic r, input logic [15:0] exp_v);
        logic [15:0] e;
        @(negedge clk);
        in_vld  = v;
        S       = s;
        A       = a;
        out_rdy = r;
        #1;
        fired    = 1'b0;
        accepted = 1'b0;
        if (out_vld === 1'b1 && out_rdy) begin
            fired    = 1'b1;
            last_out = {C, B};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL spurious_output: observed=%0h expected=none", {C, B});
            end else begin
                e = sb.pop_front();
                assert ({C, B} === e) else begin
                    n_fail++;
                    $error("FAIL result_order: observed=%0h expected=%0h", {C, B}, e);
                end
            end
        end
        if (in_vld && in_rdy === 1'b1) begin
            accepted = 1'b1;
            sb.push_back(exp_v);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [14:0] rb0, ra;
        int          sent;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        S        = '0;
        A        = '0;

        // Reset state
        #2;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_B", 32'(B), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);

        // Basic add with latency check
        step(1'b1, 15'h0005, 15'h0003, 1'b1, 16'h0008);
        chk("basic_accept", 32'(accepted), 32'd1);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("basic_lat_early", 32'(out_vld), 32'd0);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("basic_lat_fire", 32'(fired), 32'd1);
        chk("basic_B", 32'(last_out), 32'h0008);

        // Carry across the split, then wrap out of bit 14
        step(1'b1, 15'h00FF, 15'h0001, 1'b1, 16'h0100);
        step(1'b1, 15'h7FFF, 15'h0001, 1'b1, 16'h8000);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("carry_split", 32'(last_out), 32'h0100);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("wrap_carry", 32'(last_out), 32'h8000);
        drain();

        // Backpressure: two accepts then full
        step(1'b1, 15'h0001, 15'h0001, 1'b0, 16'h0002);
        chk("bp_acc1", 32'(accepted), 32'd1);
        step(1'b1, 15'h0002, 15'h0002, 1'b0, 16'h0004);
        chk("bp_acc2", 32'(accepted), 32'd1);
        step(1'b1, 15'h0003, 15'h0003, 1'b0, 16'h0006);
        chk("bp_full_in_rdy", 32'(in_rdy), 32'd0);
        chk("bp_hold_B0", 32'(B), 32'h0002);
        step(1'b1, 15'h0003, 15'h0003, 1'b0, 16'h0006);
        chk("bp_hold_B1", 32'(B), 32'h0002);
        chk("bp_hold_vld", 32'(out_vld), 32'd1);
        // Simultaneous drain: output, stage move and input on one edge
        step(1'b1, 15'h0003, 15'h0003, 1'b1, 16'h0006);
        chk("sim_in_rdy", 32'(in_rdy), 32'd1);
        chk("sim_fire", 32'(fired), 32'd1);
        chk("sim_accept", 32'(accepted), 32'd1);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("bp_second", 32'(last_out), 32'h0004);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("bp_third", 32'(last_out), 32'h0006);
        chk("bp_third_fire", 32'(fired), 32'd1);
        drain();

        // Round trip against subtraction, random handshakes
        sent = 0;
        rb0  = 15'($urandom);
        ra   = 15'($urandom);
        while (sent < 10000) begin
            step(($urandom_range(0, 3) != 0), rb0 - ra, ra, ($urandom_range(0, 3) != 0),
                 {(rb0 < ra), rb0});
            if (accepted) begin
                sent++;
                rb0 = 15'($urandom);
                ra  = 15'($urandom);
            end
        end
        drain();

        // Reset with two operands in flight
        step(1'b1, 15'h0011, 15'h0011, 1'b0, 16'h0022);
        step(1'b1, 15'h0022, 15'h0022, 1'b0, 16'h0044);
        @(posedge clk);
        in_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 32'(out_vld), 32'd0);
        chk("midrst_B", 32'(B), 32'd0);
        chk("midrst_C", 32'(C), 32'd0);
        chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
        sb.delete();
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
            chk("no_stale", 32'(out_vld), 32'd0);
        end
        step(1'b1, 15'h1234, 15'h0100, 1'b1, 16'h1334);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        step(1'b0, 15'h0, 15'h0, 1'b1, 16'h0);
        chk("post_rst_result", 32'(last_out), 32'h1334);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
